game_sequencer: RTL
===================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter LIVES, default 3: lives loaded at game start (1..3).
REQ-002 Parameter SERVE_FRAMES, default 60: frames the ball is held before launch.
REQ-003 Parameter MISS_FRAMES, default 90: frames of freeze after a miss.
REQ-004 Parameter BLINK_FRAMES, default 16: game-over blink half-period, in frames.
REQ-005 clk  input  1  pixel clock (25 MHz); all logic is on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 v_sync  input  1  V_Sync from the timing generator (active-low pulse, once per frame).
REQ-008 left  input  1  raw left button, asynchronous.
REQ-009 right  input  1  raw right button, asynchronous.
REQ-010 pad_hit  input  1  one-cycle pulse: paddle collision detected.
REQ-011 ball_miss  input  1  one-cycle pulse: ball reached the bottom edge.
REQ-012 ball_reset  output  1  high holds the ball at its serve position.
REQ-013 ball_step  output  1  one-cycle pulse: ball advances one step.
REQ-014 pad_step  output  1  one-cycle pulse: paddle may move one step.
REQ-015 score  output  8  two BCD digits, [7:4] tens and [3:0] units.
REQ-016 lives  output  2  remaining lives.
REQ-017 state  output  3  encoding IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4.
REQ-018 blink  output  1  game-over overlay enable.

Function
REQ-019 left, right and v_sync SHALL each pass through a 2-flop synchronizer before any use.
REQ-020 frame_tick SHALL be a one-cycle internal pulse on each high-to-low edge of synchronized v_sync.
- It is asserted 3 clk edges after the v_sync input falls.
REQ-021 btn_edge SHALL be a one-cycle pulse on a low-to-high edge of synchronized left OR right.
- A rising edge on both buttons in the same cycle SHALL give a single pulse.
REQ-022 A frame counter fcnt of at least 7 bits SHALL clear on every state transition.
- Outside those transitions it increments on frame_tick.
REQ-023 IDLE: ball_reset=1; ball_step=0; pad_step=0.
- btn_edge moves to SERVE and loads lives=LIVES and score=0x00 on that same edge.
REQ-024 SERVE: ball_reset=1; pad_step=frame_tick; ball_step=0.
- Moves to PLAY on the frame_tick at which fcnt==SERVE_FRAMES-1.
REQ-025 PLAY: ball_reset=0; ball_step=frame_tick; pad_step=frame_tick.
REQ-026 PLAY, pad_hit: score SHALL increment as BCD (0x09 goes to 0x10) and saturate at 0x99.
REQ-027 PLAY, ball_miss: lives SHALL decrement.
- Next state is OVER if lives was 1, otherwise MISS.
REQ-028 PLAY, pad_hit and ball_miss in the same cycle: the miss wins and score is unchanged.
REQ-029 pad_hit and ball_miss SHALL be ignored in every state except PLAY.
REQ-030 MISS: ball_reset=1; ball_step=0; pad_step=0.
- Moves to SERVE on the frame_tick at which fcnt==MISS_FRAMES-1.
REQ-031 OVER: ball_reset=1; ball_step=0; pad_step=0; score and lives are held.
- blink toggles on every frame_tick at which fcnt reaches BLINK_FRAMES-1; that fcnt then clears.
- btn_edge moves to IDLE.
REQ-032 blink SHALL be 0 in every state except OVER, and SHALL be 0 on entry to OVER.
REQ-033 All outputs SHALL be registered.
- ball_step and pad_step lag frame_tick by exactly 1 clk.
REQ-034 An undefined state encoding SHALL recover to IDLE on the next clk.

Reset
REQ-035 While reset=0, the block SHALL asynchronously force the following, with synchronizers cleared to 1 for v_sync and 0 for the buttons:
- state=IDLE, score=0x00, lives=LIVES
- ball_reset=1, ball_step=0, pad_step=0, blink=0, fcnt=0
REQ-036 Release of reset SHALL take effect on the first clk edge after reset rises; no step pulse is issued in that cycle.
REQ-037 Reset asserted in any state, mid-frame or mid-count, SHALL abort to the REQ-035 values with no residual pulses.

Verification
REQ-038 Start: reset, then pulse left -> state=SERVE within 4 clk, lives=3, score=0x00; after 60 v_sync falls -> state=PLAY.
REQ-039 Score: in PLAY, 10 pad_hit pulses -> score=0x10; 99 more pulses -> score=0x99, saturated.
REQ-040 Miss path: in PLAY with lives=3, ball_miss -> state=MISS and lives=2; after 90 frames -> SERVE.
REQ-041 Collision: in PLAY with lives=1, pad_hit and ball_miss in the same cycle -> state=OVER, lives=0, score unchanged.
REQ-042 Over: in OVER, blink toggles every 16 frames; a right-button edge -> state=IDLE and blink=0.
REQ-043 Mid-count reset: reset=0 during SERVE at fcnt=30 -> immediate IDLE values; no ball_step pulse after release until the next game reaches PLAY.

Source files
------------

// File: rtl/game_sequencer.sv
// Game-flow sequencer: IDLE/SERVE/PLAY/MISS/OVER control with a BCD score, a lives
// counter, frame-paced step pulses and a game-over blink, all derived from v_sync.
module game_sequencer #(
   parameter int LIVES        = 3,
   parameter int SERVE_FRAMES = 60,
   parameter int MISS_FRAMES  = 90,
   parameter int BLINK_FRAMES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       v_sync,
   input  logic       left,
   input  logic       right,
   input  logic       pad_hit,
   input  logic       ball_miss,
   output logic       ball_reset,
   output logic       ball_step,
   output logic       pad_step,
   output logic [7:0] score,
   output logic [1:0] lives,
   output logic [2:0] state,
   output logic       blink
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      MISS  = 3'd3,
      OVER  = 3'd4
   } state_t;

   localparam int MAX_A  = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
   localparam int MAX_F  = (MAX_A > BLINK_FRAMES) ? MAX_A : BLINK_FRAMES;
   localparam int FCNT_W = ($clog2(MAX_F) > 7) ? $clog2(MAX_F) : 7;

   localparam logic [FCNT_W-1:0] SERVE_LAST = FCNT_W'(SERVE_FRAMES - 1);
   localparam logic [FCNT_W-1:0] MISS_LAST  = FCNT_W'(MISS_FRAMES - 1);
   localparam logic [FCNT_W-1:0] BLINK_LAST = FCNT_W'(BLINK_FRAMES - 1);
   localparam logic [1:0]        LIVES_INIT = 2'(LIVES);

   state_t            cur_state, next_state;
   logic [1:0]        vs_sync, l_sync, r_sync;
   logic              vs_prev, frame_tick, btn_prev, btn_level, btn_edge;
   logic [FCNT_W-1:0] fcnt, fcnt_d;
   logic [7:0]        score_d;
   logic [1:0]        lives_d;
   logic              ball_reset_d, ball_step_d, pad_step_d, blink_d;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v == 8'h99) return v;
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   // v_sync idles high, so its synchronizer resets to 1 to avoid a fake frame edge.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vs_sync    <= 2'b11;
         vs_prev    <= 1'b1;
         frame_tick <= 1'b0;
         l_sync     <= 2'b00;
         r_sync     <= 2'b00;
         btn_prev   <= 1'b0;
      end else begin
         vs_sync    <= {vs_sync[0], v_sync};
         vs_prev    <= vs_sync[1];
         frame_tick <= vs_prev & ~vs_sync[1];
         l_sync     <= {l_sync[0], left};
         r_sync     <= {r_sync[0], right};
         btn_prev   <= btn_level;
      end
   end

   assign btn_level = l_sync[1] | r_sync[1];
   assign btn_edge  = btn_level & ~btn_prev;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cur_state <= IDLE;
      else        cur_state <= next_state;
   end

   always_comb begin
      // NOTE: a default assignment ahead of the case keeps this block free of inferred latches.
      next_state = cur_state;
      case (cur_state)
         IDLE:    if (btn_edge) next_state = SERVE;
         SERVE:   if (frame_tick && fcnt == SERVE_LAST) next_state = PLAY;
         PLAY:    if (ball_miss) next_state = (lives == 2'd1) ? OVER : MISS;
         MISS:    if (frame_tick && fcnt == MISS_LAST) next_state = SERVE;
         OVER:    if (btn_edge) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Computes next values of every registered output from the current state.
   always_comb begin
      ball_reset_d = (next_state != PLAY);
      ball_step_d  = 1'b0;
      pad_step_d   = 1'b0;
      score_d      = score;
      lives_d      = lives;
      blink_d      = blink;
      fcnt_d       = frame_tick ? fcnt + 1'b1 : fcnt;
      case (cur_state)
         IDLE: begin
            if (btn_edge) begin
               lives_d = LIVES_INIT;
               score_d = 8'h00;
            end
         end
         SERVE: pad_step_d = frame_tick;
         PLAY: begin
            ball_step_d = frame_tick;
            pad_step_d  = frame_tick;
            if (ball_miss)    lives_d = lives - 2'd1;
            else if (pad_hit) score_d = bcd_inc(score);
         end
         OVER: begin
            if (frame_tick && fcnt == BLINK_LAST) begin
               blink_d = ~blink;
               fcnt_d  = '0;
            end
         end
         default: ;
      endcase
      if (next_state != cur_state) fcnt_d  = '0;
      if (next_state != OVER)      blink_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ball_reset <= 1'b1;
         ball_step  <= 1'b0;
         pad_step   <= 1'b0;
         score      <= 8'h00;
         lives      <= LIVES_INIT;
         blink      <= 1'b0;
         fcnt       <= '0;
      end else begin
         ball_reset <= ball_reset_d;
         ball_step  <= ball_step_d;
         pad_step   <= pad_step_d;
         score      <= score_d;
         lives      <= lives_d;
         blink      <= blink_d;
         fcnt       <= fcnt_d;
      end
   end

   assign state = cur_state;

endmodule
